// File: rtl/iob_picorv32_bus_arb_pkg.sv
// Shared definitions for the PicoRV32 ibus/dbus arbiter: FSM encoding,
// port indices and the tie-break helper used in IDLE.
package iob_picorv32_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;  // instruction bus
  localparam logic PORT_D = 1'b1;  // data bus

  // Pick the next owner from the two buffer-full flags. On a tie the dbus
  // wins under fixed priority, otherwise the port not granted last wins.
  function automatic logic arb_pick(input logic full0, input logic full1,
                                    input logic last, input logic fixed_prio);
    if (full0 && full1) return fixed_prio ? PORT_D : ~last;
    return full1 ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/iob_picorv32_bus_arb_if.sv
// IOb native bus bundle. The master drives the request side, the slave
// answers with ready/rdata/rvalid.
interface iob_picorv32_bus_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (output avalid, addr, wdata, wstrb,
                  input  ready, rdata, rvalid);
  modport slave  (input  avalid, addr, wdata, wstrb,
                  output ready, rdata, rvalid);
endinterface

// File: rtl/iob_picorv32_req_buf.sv
// One-entry request buffer. Catches single-cycle avalid pulses from the
// wrapper and holds the request until the arbiter has issued it.
module iob_picorv32_req_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                avalid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                free_i,
  output logic                ready_o,
  output logic                full_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o
);

  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                capture;

  // Capture only into an empty buffer; free and capture are therefore
  // mutually exclusive in any one cycle.
  assign capture = avalid_i && !vld_q;

  // Next-state of the valid flag.
  always_comb begin
    vld_d = vld_q;
    if (capture)     vld_d = 1'b1;
    else if (free_i) vld_d = 1'b0;
  end

  // Valid flag register; also flags requests arriving while full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
    end else if (cke_i) begin
      vld_q <= vld_d;
      assert (!(avalid_i && vld_q))
        else $error("req_buf: avalid while buffer full, request ignored");
    end
  end

  // Payload register; contents only matter while vld_q is set.
  always_ff @(posedge clk_i) begin
    if (cke_i && capture) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
    end
  end

  assign ready_o = !vld_q;
  assign full_o  = vld_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

endmodule

// File: rtl/iob_picorv32_bus_arb.sv
// Shares one IOb memory port between the PicoRV32 ibus (port 0) and dbus
// (port 1). One request in flight at a time; read data is routed back to
// the port that issued the read, writes are posted.
module iob_picorv32_bus_arb
  import iob_picorv32_bus_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  iob_picorv32_bus_arb_if.slave  m0_if,
  iob_picorv32_bus_arb_if.slave  m1_if,
  iob_picorv32_bus_arb_if.master s_if
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic              full0, full1, free0, free1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [STRB_W-1:0] wstrb0, wstrb1;

  logic              s_avalid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  iob_picorv32_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_i (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cke_i    (cke_i),
    .avalid_i (m0_if.avalid),
    .addr_i   (m0_if.addr),
    .wdata_i  (m0_if.wdata),
    .wstrb_i  (m0_if.wstrb),
    .free_i   (free0),
    .ready_o  (m0_if.ready),
    .full_o   (full0),
    .addr_o   (addr0),
    .wdata_o  (wdata0),
    .wstrb_o  (wstrb0)
  );

  iob_picorv32_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_d (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cke_i    (cke_i),
    .avalid_i (m1_if.avalid),
    .addr_i   (m1_if.addr),
    .wdata_i  (m1_if.wdata),
    .wstrb_i  (m1_if.wstrb),
    .free_i   (free1),
    .ready_o  (m1_if.ready),
    .full_o   (full1),
    .addr_o   (addr1),
    .wdata_o  (wdata1),
    .wstrb_o  (wstrb1)
  );

  // Memory-side request is always the owner's buffer; avalid qualifies it.
  always_comb begin
    sel_addr  = (owner_q == PORT_D) ? addr1  : addr0;
    sel_wdata = (owner_q == PORT_D) ? wdata1 : wdata0;
    sel_wstrb = (owner_q == PORT_D) ? wstrb1 : wstrb0;
  end

  // Arbitration FSM: next state, owner/last-grant updates, buffer release.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    free0    = 1'b0;
    free1    = 1'b0;
    s_avalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full0 || full1) begin
          owner_d = arb_pick(full0, full1, last_q, FIXED_PRIO != 0);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_avalid = 1'b1;
        if (s_if.ready) begin
          free0   = (owner_q == PORT_I);
          free1   = (owner_q == PORT_D);
          last_d  = owner_q;
          state_d = (sel_wstrb != '0) ? ST_IDLE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (s_if.rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last-grant resets to the dbus so the ibus wins the
  // first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_I;
      last_q  <= PORT_D;
    end else if (cke_i) begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign s_if.avalid = s_avalid;
  assign s_if.addr   = sel_addr;
  assign s_if.wdata  = sel_wdata;
  assign s_if.wstrb  = sel_wstrb;

  // Read data fans out to both ports; only the owner's rvalid is raised,
  // and stray responses outside WAIT_RD are dropped.
  assign m0_if.rdata  = s_if.rdata;
  assign m1_if.rdata  = s_if.rdata;
  assign m0_if.rvalid = (state_q == ST_WAIT_RD) && (owner_q == PORT_I) && s_if.rvalid;
  assign m1_if.rvalid = (state_q == ST_WAIT_RD) && (owner_q == PORT_D) && s_if.rvalid;

endmodule
